sha_nonce_sequencer: RTL and testbench

- Control FSM for the SHA-256 round datapath of the miner.
- Drives the core's `block` and `select` inputs and builds its `msg_in` word stream from an 80-byte header register file plus an internal nonce counter.
- Runs the full double-hash sequence (block 0, block 1, block 2) for every nonce in a range.
- Checks the final digest word against a leading-zero target; stops on a hit or when the range is exhausted.

---
 rtl/sha_nonce_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sha_nonce_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sha_nonce_sequencer.sv
// Nonce sequencer for the SHA-256 round core: walks a nonce range through
// the three-block double hash and checks each final digest against a target.
module sha_nonce_sequencer #(
  parameter int ROUNDS    = 64,
  parameter int GAP       = 2,
  parameter int ZERO_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] nonce_first,
  input  logic [31:0] nonce_last,
  input  logic [31:0] hdr_word,
  input  logic [31:0] dig_h8,
  output logic [4:0]  hdr_addr,
  output logic [1:0]  block,
  output logic [6:0]  select,
  output logic [31:0] msg_in,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] nonce_out
);

  localparam logic [6:0] SEL_END = 7'(ROUNDS + GAP - 1);
  localparam int         SHIFT   = 32 - ZERO_BITS;

  typedef enum logic [2:0] {
    IDLE,
    RUN0,
    RUN1,
    RUN2,
    CHECK
  } state_t;

  state_t      state, state_n;
  logic [6:0]  sel_q, sel_n;
  logic [31:0] nonce_q, nonce_n;
  logic [31:0] last_q, last_n;
  logic [31:0] out_q, out_n;
  logic        done_q, done_n;
  logic        found_q, found_n;
  logic        hit;
  logic        sel_end;

  assign hit     = (dig_h8 >> SHIFT) == 32'd0;
  assign sel_end = sel_q == SEL_END;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      nonce_q <= '0;
      last_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      nonce_q <= nonce_n;
      last_q  <= last_n;
      out_q   <= out_n;
      done_q  <= done_n;
      found_q <= found_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    nonce_n = nonce_q;
    last_n  = last_q;
    out_n   = out_q;
    done_n  = 1'b0;
    found_n = found_q;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = RUN0;
          sel_n   = '0;
          nonce_n = nonce_first;
          last_n  = nonce_last;
          found_n = 1'b0;
        end
      end
      RUN0: begin
        sel_n = sel_end ? 7'd0 : sel_q + 7'd1;
        if (sel_end) state_n = RUN1;
      end
      RUN1: begin
        sel_n = sel_end ? 7'd0 : sel_q + 7'd1;
        if (sel_end) state_n = RUN2;
      end
      RUN2: begin
        // select parks on its last value through CHECK
        if (sel_end) state_n = CHECK;
        else sel_n = sel_q + 7'd1;
      end
      CHECK: begin
        sel_n = '0;
        if (hit) begin
          state_n = IDLE;
          done_n  = 1'b1;
          found_n = 1'b1;
          out_n   = nonce_q;
        end else if (nonce_q == last_q) begin
          state_n = IDLE;
          done_n  = 1'b1;
          found_n = 1'b0;
          out_n   = last_q;
        end else begin
          state_n = RUN0;
          nonce_n = nonce_q + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      sel_n   = '0;
      done_n  = 1'b0;
      found_n = 1'b0;
    end
  end

  always_comb begin
    block = 2'd0;
    unique case (state)
      RUN1:        block = 2'd1;
      RUN2, CHECK: block = 2'd2;
      default:     block = 2'd0;
    endcase
  end

  // Block 0 carries header words 0..15; block 1 the rest plus nonce and padding
  always_comb begin
    msg_in   = '0;
    hdr_addr = '0;
    unique case (1'b1)
      (state == RUN0) && (sel_q < 7'd16): begin
        hdr_addr = sel_q[4:0];
        msg_in   = hdr_word;
      end
      (state == RUN1) && (sel_q < 7'd3): begin
        hdr_addr = 5'd16 + sel_q[4:0];
        msg_in   = hdr_word;
      end
      (state == RUN1) && (sel_q == 7'd3):
        msg_in = nonce_q;
      (state == RUN1) && (sel_q == 7'd4):
        msg_in = 32'h8000_0000;
      (state == RUN1) && (sel_q == 7'd15):
        msg_in = 32'h0000_0280;
      default: ;
    endcase
  end

  assign select    = sel_q;
  assign busy      = state != IDLE;
  assign done      = done_q;
  assign found     = found_q;
  assign nonce_out = out_q;

endmodule

// File: tb/tb_sha_nonce_sequencer.sv
// Randomized bench for sha_nonce_sequencer with a cycle-position model
// of the block/select/message schedule.
module tb_sha_nonce_sequencer;

  localparam int SPAN = 66;
  localparam int PER  = 3 * SPAN + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] nonce_first;
  logic [31:0] nonce_last;
  logic [31:0] hdr_word;
  logic [31:0] dig_h8;
  logic [4:0]  hdr_addr;
  logic [1:0]  block;
  logic [6:0]  select;
  logic [31:0] msg_in;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] nonce_out;

  logic [31:0] hdr_mem [32];
  int total = 0;
  int bad   = 0;

  sha_nonce_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .hdr_word    (hdr_word),
    .dig_h8      (dig_h8),
    .hdr_addr    (hdr_addr),
    .block       (block),
    .select      (select),
    .msg_in      (msg_in),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .nonce_out   (nonce_out)
  );

  always #5 clk = ~clk;

  assign hdr_word = hdr_mem[hdr_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_block"}, 32'(block), 32'd0);
    chk({tag, "_select"}, 32'(select), 32'd0);
    chk({tag, "_msg"}, msg_in, 32'd0);
    chk({tag, "_addr"}, 32'(hdr_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_nout"}, nonce_out, 32'd0);
  endtask

  // r = cycle position within one nonce's 199-cycle period
  task automatic chk_cycle(input int r, input logic [31:0] n);
    int blk, sl;
    logic [31:0] em, ea;
    blk = (r == PER - 1) ? 2 : r / SPAN;
    sl  = (r == PER - 1) ? SPAN - 1 : r % SPAN;
    em  = 32'd0;
    ea  = 32'd0;
    if (blk == 0 && sl < 16) begin
      ea = 32'(sl);
      em = hdr_mem[sl];
    end else if (blk == 1 && sl < 3) begin
      ea = 32'(16 + sl);
      em = hdr_mem[16 + sl];
    end else if (blk == 1 && sl == 3) em = n;
    else if (blk == 1 && sl == 4) em = 32'h8000_0000;
    else if (blk == 1 && sl == 15) em = 32'h0000_0280;
    chk("run_block", 32'(block), 32'(blk));
    chk("run_select", 32'(select), 32'(sl));
    chk("run_msg", msg_in, em);
    chk("run_addr", 32'(hdr_addr), ea);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_done", 32'(done), 32'd0);
  endtask

  task automatic run(input logic [31:0] first, input logic [31:0] last,
                     input bit hit_en, input logic [31:0] hit_n,
                     input int abort_at, input int busy_start_at,
                     input int rst_at);
    logic [31:0] n;
    int k;
    bit fin;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    nonce_first = first;
    nonce_last = last;
    n = first;
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      start = 1'b0;
      nonce_first = $urandom;
      nonce_last = $urandom;
      chk_cycle(k % PER, n);
      if (k == 0) chk("start_found_clr", 32'(found), 32'd0);
      if (k == busy_start_at) start = 1'b1;
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_block", 32'(block), 32'd0);
        chk("abort_select", 32'(select), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_found", 32'(found), 32'd0);
        @(negedge clk);
        chk("abort_done2", 32'(done), 32'd0);
        fin = 1'b1;
      end else if (k == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("after_rst");
        fin = 1'b1;
      end else if (k % PER == PER - 1) begin
        dig_h8 = (hit_en && n == hit_n) ? 32'd0 : ($urandom | 32'd1);
        if (dig_h8 == 32'd0 || n == last) begin
          @(negedge clk);
          chk("done_pulse", 32'(done), 32'd1);
          chk("done_found", 32'(found), 32'(dig_h8 == 32'd0));
          chk("done_nonce", nonce_out, n);
          chk("done_busy", 32'(busy), 32'd0);
          @(negedge clk);
          chk("done_clear", 32'(done), 32'd0);
          chk("hold_found", 32'(found), 32'(dig_h8 == 32'd0));
          chk("hold_nonce", nonce_out, n);
          fin = 1'b1;
        end else begin
          n = n + 32'd1;
        end
      end else begin
        dig_h8 = $urandom;
      end
      k++;
    end
  endtask

  initial begin
    logic [31:0] f;
    int len;
    bit he;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    nonce_first = '0;
    nonce_last = '0;
    dig_h8 = '0;
    for (int i = 0; i < 32; i++) hdr_mem[i] = 32'(i) * 32'h0101_0101;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    run(32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0, -1, -1, -1);
    run(32'd5, 32'd9, 1'b1, 32'd7, -1, -1, -1);
    run(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'd0, -1, -1, -1);
    run(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, -1, -1, -1);
    run(32'd0, 32'd100, 1'b0, 32'd0, SPAN + 30, 10, -1);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_select", 32'(select), 32'd0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) hdr_mem[i] = $urandom;
      f = $urandom;
      len = $urandom_range(0, 2);
      he = 1'($urandom_range(0, 1));
      run(f, f + 32'(len), he, f + 32'($urandom_range(0, len)), -1, -1, -1);
    end

    run(32'h0000_00AA, 32'h0000_00AA, 1'b0, 32'd0, -1, -1, 2 * SPAN + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
